// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// the stage-index type and a highest-set-bit helper used for hold/flush points.
package hazard_pkg;

    localparam int MAX_STAGE = 32;
    localparam int IDX_W     = 5;

    typedef logic [IDX_W-1:0] stage_idx_t;

    localparam stage_idx_t STG_F = stage_idx_t'(0);
    localparam stage_idx_t STG_D = stage_idx_t'(1);
    localparam stage_idx_t STG_X = stage_idx_t'(2);
    localparam stage_idx_t STG_M = stage_idx_t'(3);
    localparam stage_idx_t STG_W = stage_idx_t'(4);

    typedef struct packed {
        logic       found;
        stage_idx_t idx;
    } hsb_t;

    function automatic hsb_t highest_set(input logic [MAX_STAGE-1:0] vec);
        hsb_t r;
        r = '0;
        for (int i = 0; i < MAX_STAGE; i++) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = stage_idx_t'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stall_timer.sv
// Timed multi-cycle stall: down-counter, latched stage, busy, sticky error
// and same-cycle cancel. The start cycle is made effective via a bypass.
module stall_timer
    import hazard_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  stage_idx_t       start_stage,
    input  logic [LEN_W-1:0] start_len,
    input  logic             cancel,
    output logic             active,
    output stage_idx_t       active_stage,
    output logic             busy,
    output logic             err
);

    logic [LEN_W-1:0] cnt_q;
    stage_idx_t       stage_q;
    logic             err_q;
    logic             start_ok;

    assign busy         = (cnt_q != '0);
    assign start_ok     = start && !busy && (start_len != '0);
    assign active       = busy || start_ok;
    assign active_stage = start_ok ? start_stage : stage_q;
    assign err          = err_q;

    // Counter holds the cycles still to stall after the current one.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            stage_q <= STG_F;
            err_q   <= 1'b0;
        end else begin
            if (start && busy) begin
                err_q <= 1'b1;
            end
            if (cancel) begin
                cnt_q <= '0;
            end else if (start_ok) begin
                cnt_q   <= start_len - LEN_W'(1);
                stage_q <= start_stage;
            end else if (busy) begin
                cnt_q <= cnt_q - LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage enables, bubbles and flushes from stall,
// flush and timed-stall requests. Optional counters: define HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 5,
    parameter int LEN_W  = 4
`ifdef HAZ_PERF_CNT_EN
   ,parameter int CNT_W  = 32
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NSTAGE-1:0]          stall_req,
    input  logic [NSTAGE-1:0]          flush_req,
    input  logic                       mc_start,
    input  logic [$clog2(NSTAGE)-1:0]  mc_stage,
    input  logic [LEN_W-1:0]           mc_len,
    output logic [NSTAGE-1:0]          en,
    output logic [NSTAGE-1:0]          bubble,
    output logic                       mc_busy,
    output logic                       mc_err
`ifdef HAZ_PERF_CNT_EN
   ,output logic [CNT_W-1:0]           perf_stall_cyc,
    output logic [CNT_W-1:0]           perf_flush_cnt
`endif
);

    stage_idx_t             mc_stage_clamped;
    logic                   tmr_active;
    stage_idx_t             tmr_stage;
    logic                   tmr_cancel;
    logic [MAX_STAGE-1:0]   stall_vec;
    logic [MAX_STAGE-1:0]   flush_vec;
    hsb_t                   hold;
    hsb_t                   flush;
    logic                   flush_ok;
    logic                   hold_any;

    assign mc_stage_clamped = (stage_idx_t'(mc_stage) >= stage_idx_t'(NSTAGE)) ?
                              stage_idx_t'(NSTAGE - 1) : stage_idx_t'(mc_stage);

    stall_timer #(.LEN_W(LEN_W)) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mc_start),
        .start_stage  (mc_stage_clamped),
        .start_len    (mc_len),
        .cancel       (tmr_cancel),
        .active       (tmr_active),
        .active_stage (tmr_stage),
        .busy         (mc_busy),
        .err          (mc_err)
    );

    // An honoured flush is always older than the timed stall, so it cancels it.
    assign tmr_cancel = flush_ok && tmr_active;
    assign hold_any   = hold.found && !flush_ok;

    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        stall_vec = '0;
        flush_vec = '0;
        en        = '1;
        bubble    = '0;
        stall_vec[NSTAGE-1:0] = stall_req;
        flush_vec[NSTAGE-1:0] = flush_req;
        if (tmr_active) begin
            stall_vec[tmr_stage] = 1'b1;
        end
        hold     = highest_set(stall_vec);
        flush    = highest_set(flush_vec);
        flush_ok = flush.found && (!hold.found || (flush.idx > hold.idx));

        if (!rst_n) begin
            en     = '0;
            bubble = '1;
        end else if (flush_ok) begin
            for (int k = 0; k < NSTAGE; k++) begin
                bubble[k] = (k < int'(flush.idx));
            end
        end else if (hold.found) begin
            for (int k = 0; k < NSTAGE; k++) begin
                en[k]     = (k > int'(hold.idx));
                bubble[k] = (k == int'(hold.idx) + 1);
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (hold_any && !(&perf_stall_cyc)) begin
                perf_stall_cyc <= perf_stall_cyc + CNT_W'(1);
            end
            if (flush_ok && !(&perf_flush_cnt)) begin
                perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_hold_any;
    assign unused_hold_any = hold_any;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (NSTAGE=5, LEN_W=4).
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] stall_req;
    logic [4:0] flush_req;
    logic       mc_start;
    logic [2:0] mc_stage;
    logic [3:0] mc_len;
    logic [4:0] en;
    logic [4:0] bubble;
    logic       mc_busy;
    logic       mc_err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pipe_hazard_ctrl #(.NSTAGE(5), .LEN_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_req      (stall_req),
        .flush_req      (flush_req),
        .mc_start       (mc_start),
        .mc_stage       (mc_stage),
        .mc_len         (mc_len),
        .en             (en),
        .bubble         (bubble),
        .mc_busy        (mc_busy),
        .mc_err         (mc_err)
`ifdef HAZ_PERF_CNT_EN
       ,.perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic [4:0] s, input logic [4:0] f, input logic st,
                         input logic [2:0] stg, input logic [3:0] len);
        @(negedge clk);
        stall_req = s;
        flush_req = f;
        mc_start  = st;
        mc_stage  = stg;
        mc_len    = len;
        #1;
    endtask

    task automatic idle();
        drive(5'b00000, 5'b00000, 1'b0, 3'd0, 4'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        stall_req = '0;
        flush_req = '0;
        mc_start  = 1'b0;
        mc_stage  = '0;
        mc_len    = '0;
        #3;
        check("rst_en",     32'(en),      32'h00);
        check("rst_bubble", 32'(bubble),  32'h1f);
        check("rst_busy",   32'(mc_busy), 32'h0);
        check("rst_err",    32'(mc_err),  32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check("idle_en",     32'(en),     32'h1f);
        check("idle_bubble", 32'(bubble), 32'h00);

        drive(5'b00100, 5'b00000, 1'b0, 3'd0, 4'd0);
        check("stall2_en",     32'(en),     32'h18);
        check("stall2_bubble", 32'(bubble), 32'h08);

        drive(5'b00000, 5'b00100, 1'b0, 3'd0, 4'd0);
        check("flush2_en",     32'(en),     32'h1f);
        check("flush2_bubble", 32'(bubble), 32'h03);

        drive(5'b01000, 5'b00100, 1'b0, 3'd0, 4'd0);
        check("flush_held_en",     32'(en),     32'h10);
        check("flush_held_bubble", 32'(bubble), 32'h10);

        // Timed stall on stage 2 for 3 cycles, with a restart attempt at t+1
        drive(5'b00000, 5'b00000, 1'b1, 3'd2, 4'd3);
        check("mc_t0_en",   32'(en),      32'h18);
        check("mc_t0_bub",  32'(bubble),  32'h08);
        check("mc_t0_busy", 32'(mc_busy), 32'h0);
        drive(5'b00000, 5'b00000, 1'b1, 3'd4, 4'd5);
        check("mc_t1_en",   32'(en),      32'h18);
        check("mc_t1_busy", 32'(mc_busy), 32'h1);
        check("mc_t1_err",  32'(mc_err),  32'h0);
        idle();
        check("mc_t2_en",   32'(en),      32'h18);
        check("mc_t2_busy", 32'(mc_busy), 32'h1);
        check("mc_t2_err",  32'(mc_err),  32'h1);
        idle();
        check("mc_t3_en",   32'(en),      32'h1f);
        check("mc_t3_busy", 32'(mc_busy), 32'h0);

        drive(5'b00000, 5'b00000, 1'b1, 3'd3, 4'd0);
        check("len0_en", 32'(en), 32'h1f);
        idle();
        check("len0_busy", 32'(mc_busy), 32'h0);
        check("err_sticky", 32'(mc_err), 32'h1);

        // Flush older than the timed stall cancels it
        drive(5'b00000, 5'b00000, 1'b1, 3'd1, 4'd4);
        check("cancel_t0_en",  32'(en),     32'h1c);
        check("cancel_t0_bub", 32'(bubble), 32'h04);
        drive(5'b00000, 5'b01000, 1'b0, 3'd0, 4'd0);
        check("cancel_busy",   32'(mc_busy), 32'h1);
        check("cancel_en",     32'(en),      32'h1f);
        check("cancel_bubble", 32'(bubble),  32'h07);
        idle();
        check("cancel_after_busy", 32'(mc_busy), 32'h0);
        check("cancel_after_en",   32'(en),      32'h1f);

        // Out-of-range stage clamps to W; no stage above W to bubble
        drive(5'b00000, 5'b00000, 1'b1, 3'd7, 4'd2);
        check("clamp_en",  32'(en),     32'h00);
        check("clamp_bub", 32'(bubble), 32'h00);
        idle();
        check("clamp_t1_en",   32'(en),      32'h00);
        check("clamp_t1_busy", 32'(mc_busy), 32'h1);
        idle();
        check("clamp_t2_en", 32'(en), 32'h1f);

        drive(5'b01000, 5'b10000, 1'b0, 3'd0, 4'd0);
        check("flush4_en",     32'(en),     32'h1f);
        check("flush4_bubble", 32'(bubble), 32'h0f);

        // Reset in the middle of a long timed stall
        drive(5'b00000, 5'b00000, 1'b1, 3'd2, 4'd8);
        check("pre_rst_en", 32'(en), 32'h18);
        @(negedge clk);
        rst_n    = 1'b0;
        mc_start = 1'b0;
        mc_len   = '0;
        #1;
        check("midrst_en",     32'(en),      32'h00);
        check("midrst_bubble", 32'(bubble),  32'h1f);
        check("midrst_busy",   32'(mc_busy), 32'h0);
        check("midrst_err",    32'(mc_err),  32'h0);
`ifdef HAZ_PERF_CNT_EN
        check("midrst_pstall", perf_stall_cyc, 32'd0);
        check("midrst_pflush", perf_flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check("rel_en",     32'(en),      32'h1f);
        check("rel_bubble", 32'(bubble),  32'h00);
        check("rel_busy",   32'(mc_busy), 32'h0);
        idle();
        check("rel_t1_en", 32'(en), 32'h1f);

`ifdef HAZ_PERF_CNT_EN
        drive(5'b00010, 5'b00000, 1'b0, 3'd0, 4'd0);
        drive(5'b00000, 5'b00010, 1'b0, 3'd0, 4'd0);
        drive(5'b00100, 5'b00010, 1'b0, 3'd0, 4'd0);
        idle();
        check("perf_stall", perf_stall_cyc, 32'd2);
        check("perf_flush", perf_flush_cnt, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
